draw_scheduler: RTL
===================

// Module: draw_scheduler
// PURPOSE
//   Shares the single block_drawer between NUM_REQ drawing clients (floor init, falling block, eraser).
//   Accepts requests of the form (x, y, colour, size), arbitrates round-robin, issues one draw at a time,
//   waits for drawer completion and returns a one-cycle ack to the winner. Sits between game FSM and block_drawer.
// PARAMETERS
//   NUM_REQ        3      number of requesters (2..8)
//   TIMEOUT_CYCLES 65535  drawer watchdog limit, used only with DRAW_TIMEOUT_EN
// PORTS
//   clock        in   1            system clock (CLOCK_50 domain)
//   resetn       in   1            asynchronous, active-low reset
//   req          in   NUM_REQ      level request per client; hold until ack
//   req_x        in   8*NUM_REQ    start x per client, client i at [8i+7:8i]
//   req_y        in   7*NUM_REQ    start y per client, client i at [7i+6:7i]
//   req_colour   in   3*NUM_REQ    colour per client
//   req_size     in   4*NUM_REQ    block edge length per client
//   ack          out  NUM_REQ      one-cycle completion pulse to the granted client
//   busy         out  1            high from grant until the ack cycle inclusive
//   drw_start    out  1            one-cycle start pulse to block_drawer
//   drw_x/drw_y  out  8/7          latched coordinates to block_drawer
//   drw_colour   out  3            latched colour
//   drw_size     out  4            latched size
//   drw_finished in   1            block_drawer completion level/pulse
//   err          out  1            sticky watchdog flag
// BEHAVIOUR
//   - Reset: state IDLE, rr pointer = 0, ack=0, busy=0, drw_start=0, drw_x/y/colour/size=0, err=0.
//     Reset mid-operation aborts immediately; drw_start drops asynchronously; no ack issued.
//   - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//     IDLE: if |req, pick winner g = first set bit searching from ptr upward with wrap; latch req_*[g]
//       into drw_*; store g; busy=1; -> ISSUE. No req: stay.
//     ISSUE: drw_start=1 for exactly this cycle; -> WAIT.
//     WAIT: stay until drw_finished==1 sampled; drw_finished during ISSUE is ignored.
//     DONE: ack[g]=1 for one cycle; ptr = (g+1) mod NUM_REQ; busy=0 next cycle; -> IDLE.
//   - Latency: req rising at cycle 0 in IDLE -> drw_start at cycle 1; ack one cycle after finished
//     is sampled. Minimum back-to-back period is 4 cycles plus drawer time.
//   - drw_* are stable from ISSUE through DONE; req_* may change after grant without effect.
//   - A req dropped after grant does not cancel the draw; ack still pulses.
//   - Simultaneous requests: lowest index at or above ptr wins; ptr wrap NUM_REQ-1 -> 0.
//   - A client re-raising req in its ack cycle is considered only in the following IDLE cycle,
//     behind any waiting client per round-robin order.
//   - At most one ack bit is high per cycle; ack is never high while drw_start is high.
// CONFIGURATION
//   DRAW_TIMEOUT_EN defined: a 16-bit counter runs in WAIT. At TIMEOUT_CYCLES without drw_finished,
//     go to DONE, ack the client normally and set err=1. err stays set until reset.
//   DRAW_TIMEOUT_EN undefined: no counter; WAIT is unbounded; err tied to 0.
// STRUCTURE
//   tap_pkg: coordinate widths (X_W=8, Y_W=7, COL_W=3, SIZE_W=4), colour constants
//     (COL_BLACK=3'b000, COL_FLOOR=3'b001, COL_BLOCK=3'b111), FSM state encodings.
//   Sub-module rr_arbiter: combinational round-robin winner select from (req, ptr) -> (valid, g).
//   FSM, latches and watchdog stay in draw_scheduler.
// TESTING
//   1 Single: req=001, x=15, y=104, col=1, size=15 -> drw_start 1 cycle later with those values;
//     finished after 20 cycles -> ack=001 for one cycle, busy low.
//   2 Contention: req=011 from reset -> client 0 served first, then client 1. ptr ends at 2.
//   3 Fairness: req=111 held, finished 5 cycles after each start -> grant order 0,1,2,0,1,2; no client
//     granted twice in a row.
//   4 Drop after grant: req[1] deasserted in WAIT -> draw completes, ack[1] still pulses.
//   5 Reset in WAIT: resetn low -> all outputs 0 at once; after release, pending req=100 served by
//     client 2 with ptr=0 order.
//   6 DRAW_TIMEOUT_EN, TIMEOUT_CYCLES=10, drw_finished held 0 -> ack after 10 WAIT cycles, err=1,
//     err stays 1 across later normal draws.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared widths, colour codes and FSM encoding for the draw scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_scheduler_pkg;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int COL_W  = 3;
    localparam int SIZE_W = 4;

    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COL_W-1:0] COL_FLOOR = 3'b001;
    localparam logic [COL_W-1:0] COL_BLOCK = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// Bundles the client request/ack bus and the block_drawer command bus.
// Latency: n/a (wiring only).
// Backpressure: clients hold req until ack; drawer completion via drw_finished.
interface draw_scheduler_if #(
    parameter int NUM_REQ = 3
);
    import draw_scheduler_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [X_W*NUM_REQ-1:0]    req_x;
    logic [Y_W*NUM_REQ-1:0]    req_y;
    logic [COL_W*NUM_REQ-1:0]  req_colour;
    logic [SIZE_W*NUM_REQ-1:0] req_size;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic                      drw_start;
    logic [X_W-1:0]            drw_x;
    logic [Y_W-1:0]            drw_y;
    logic [COL_W-1:0]          drw_colour;
    logic [SIZE_W-1:0]         drw_size;
    logic                      drw_finished;
    logic                      err;

    // Scheduler side.
    modport slave (
        input  req, req_x, req_y, req_colour, req_size, drw_finished,
        output ack, busy, drw_start, drw_x, drw_y, drw_colour, drw_size, err
    );

    // Clients and drawer side.
    modport master (
        output req, req_x, req_y, req_colour, req_size, drw_finished,
        input  ack, busy, drw_start, drw_x, drw_y, drw_colour, drw_size, err
    );

endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Round-robin winner select: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               vld_o,
    output logic [PTR_W-1:0]   g_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PTR_W:0]       sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set offset, map back.
    always_comb begin
        req_dbl = {req_i, req_i};
        rot     = req_dbl[ptr_i +: NUM_REQ];
        vld_o   = |rot;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            end
        end
        if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
            sum = sum - (PTR_W + 1)'(NUM_REQ);
        end
        g_o = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares one block_drawer between NUM_REQ clients, round-robin, one draw at a time.
// Latency: req in IDLE -> drw_start next cycle; ack one cycle after drw_finished is sampled.
// Backpressure: clients hold req until ack; optional watchdog under macro DRAW_TIMEOUT_EN.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3
`ifdef DRAW_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic            clock,
    input  logic            resetn,
    draw_scheduler_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    g_q, g_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SIZE_W-1:0]   size_q, size_d;

    logic                arb_vld;
    logic [PTR_W-1:0]    arb_g;

    logic [X_W-1:0]      rx [NUM_REQ];
    logic [Y_W-1:0]      ry [NUM_REQ];
    logic [COL_W-1:0]    rc [NUM_REQ];
    logic [SIZE_W-1:0]   rs [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign rx[i] = bus.req_x[i*X_W +: X_W];
        assign ry[i] = bus.req_y[i*Y_W +: Y_W];
        assign rc[i] = bus.req_colour[i*COL_W +: COL_W];
        assign rs[i] = bus.req_size[i*SIZE_W +: SIZE_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .vld_o   (arb_vld),
        .g_o     (arb_g)
    );

`ifdef DRAW_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // Next-state, latch capture and decoded outputs.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        g_d            = g_q;
        x_d            = x_q;
        y_d            = y_q;
        col_d          = col_q;
        size_d         = size_q;
`ifdef DRAW_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        bus.drw_start  = (state_q == ST_ISSUE);
        bus.busy       = (state_q != ST_IDLE);
        bus.ack        = (state_q == ST_DONE) ? (NUM_REQ'(1) << g_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    g_d     = arb_g;
                    x_d     = rx[arb_g];
                    y_d     = ry[arb_g];
                    col_d   = rc[arb_g];
                    size_d  = rs[arb_g];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // drw_finished is deliberately ignored here.
                state_d = ST_WAIT;
`ifdef DRAW_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.drw_finished) begin
                    state_d = ST_DONE;
                end
`ifdef DRAW_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                ptr_d   = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, round-robin pointer and latched draw command.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            size_q  <= size_d;
        end
    end

`ifdef DRAW_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.drw_x      = x_q;
    assign bus.drw_y      = y_q;
    assign bus.drw_colour = col_q;
    assign bus.drw_size   = size_q;

endmodule
